// File: rtl/bn_pkg.sv
// Shared encodings for the batch-norm parameter loader: table selects and FSM states.
package bn_pkg;

    typedef enum logic [1:0] {
        BN_SEL_BETA  = 2'd0,
        BN_SEL_GAMMA = 2'd1,
        BN_SEL_MMEAN = 2'd2,
        BN_SEL_MVAR  = 2'd3
    } bn_sel_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StLoad = 2'd2,
        StFin  = 2'd3
    } bn_state_e;

endpackage

// File: rtl/bn_param_loader_if.sv
// Parameter stream in, table write port out; master drives the stream, slave is the loader.
interface bn_param_loader_if #(
    parameter int unsigned FLOAT_BIT = 8,
    parameter int unsigned FILTERS   = 64
);
    localparam int unsigned AW = $clog2(FILTERS);

    logic                 s_valid;
    logic                 s_ready;
    logic [FLOAT_BIT-1:0] s_data;
    logic                 wr_en;
    logic [1:0]           wr_sel;
    logic [AW-1:0]        wr_addr;
    logic [FLOAT_BIT-1:0] wr_data;

    modport master (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_sel, wr_addr, wr_data
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_sel, wr_addr, wr_data
    );

endinterface

// File: rtl/bn_param_addr_cnt.sv
// Table/index counter pair: index walks 0..FILTERS-1, then carries into the table select.
module bn_param_addr_cnt
    import bn_pkg::*;
#(
    parameter int unsigned FILTERS = 64,
    localparam int unsigned AW = $clog2(FILTERS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clear,
    output logic [1:0]    tbl,
    output logic [AW-1:0] index,
    output logic          last
);

    localparam logic [AW-1:0] IdxMax = AW'(FILTERS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl   <= 2'd0;
            index <= '0;
        end else if (clear) begin
            tbl   <= 2'd0;
            index <= '0;
        end else if (inc) begin
            if (index == IdxMax) begin
                index <= '0;
                tbl   <= tbl + 2'd1;
            end else begin
                index <= index + AW'(1);
            end
        end
    end

    assign last = (tbl == BN_SEL_MVAR) && (index == IdxMax);

endmodule

// File: rtl/bn_param_loader.sv
// Loads beta/gamma/mean/variance tables from a SYNC-prefixed word stream, one write per beat.
module bn_param_loader
    import bn_pkg::*;
#(
    parameter int unsigned        FLOAT_BIT = 8,
    parameter int unsigned        FILTERS   = 64,
    parameter logic [FLOAT_BIT-1:0] SYNC    = FLOAT_BIT'(8'hA5)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    bn_param_loader_if.slave    bus,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned AW = $clog2(FILTERS);

    bn_state_e state_q, state_d;

    logic                 s_ready;
    logic                 beat;
    logic                 cnt_inc, cnt_clear, cnt_last;
    logic [1:0]           cnt_tbl;
    logic [AW-1:0]        cnt_index;
    logic                 wr_en_d, done_d, err_d;
    logic                 wr_en_q, done_q, err_q;
    logic [1:0]           wr_sel_q;
    logic [AW-1:0]        wr_addr_q;
    logic [FLOAT_BIT-1:0] wr_data_q;

    bn_param_addr_cnt #(
        .FILTERS (FILTERS)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .clear (cnt_clear),
        .tbl   (cnt_tbl),
        .index (cnt_index),
        .last  (cnt_last)
    );

    assign s_ready = (state_q == StHdr) || (state_q == StLoad);
    assign beat    = bus.s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        cnt_inc   = 1'b0;
        cnt_clear = 1'b0;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StHdr;
            end
            StHdr: begin
                if (beat) begin
                    if (bus.s_data == SYNC) begin
                        state_d   = StLoad;
                        cnt_clear = 1'b1;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (beat) begin
                    cnt_inc = 1'b1;
                    wr_en_d = 1'b1;
                    // done is registered alongside the final write so both land in StFin
                    if (cnt_last) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_sel_q  <= 2'd0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (wr_en_d) begin
                wr_sel_q  <= cnt_tbl;
                wr_addr_q <= cnt_index;
                wr_data_q <= bus.s_data;
            end
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_sel  = wr_sel_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign err         = err_q;

endmodule
